// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 pipeline.
//   RESET_PC  - PC value after reset
//   NOP_INSTR - sll $0,$0,0, injected into IF/ID as a bubble
//   npc_sel_e - next-PC source select (SEQ, BR, JR, J)
//   INSTR_W   - instruction / address width
package mips_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEQ = 2'd0,
      BR  = 2'd1,
      JR  = 2'd2,
      J   = 2'd3
   } npc_sel_e;

   // Targets are forced onto a word boundary; no misalignment trap exists.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC selection for the fetch stage.
// Inputs : pc_in, branch/jr/jump requests and their targets.
// Outputs: sel_out      - chosen source (npc_sel_e encoding)
//          next_pc_out  - aligned redirect target, or PC+4 when SEQ
//          pc_plus4_out - pc_in + 4, wrapping modulo 2^32
module next_pc_select
   import mips_pkg::*;
(
   input  logic [INSTR_W-1:0] pc_in,
   input  logic               branch_taken_in,
   input  logic [INSTR_W-1:0] branch_target_in,
   input  logic               jr_in,
   input  logic [INSTR_W-1:0] jr_target_in,
   input  logic               jump_in,
   input  logic [INSTR_W-1:0] jump_target_in,
   output logic [1:0]         sel_out,
   output logic [INSTR_W-1:0] next_pc_out,
   output logic [INSTR_W-1:0] pc_plus4_out
);

   npc_sel_e           w_sel;
   logic [INSTR_W-1:0] w_pc_plus4;

   assign w_pc_plus4 = pc_in + 32'd4;

   // The branch belongs to the older instruction in EX, so it beats the
   // JR/J decoded in ID, which is then on the wrong path.
   always_comb begin
      w_sel = SEQ;
      if (branch_taken_in)
         w_sel = BR;
      else if (jr_in)
         w_sel = JR;
      else if (jump_in)
         w_sel = J;
   end

   always_comb begin
      next_pc_out = w_pc_plus4;
      case (w_sel)
         BR:      next_pc_out = align_word(branch_target_in);
         JR:      next_pc_out = align_word(jr_target_in);
         J:       next_pc_out = align_word(jump_target_in);
         default: next_pc_out = w_pc_plus4;
      endcase
   end

   assign sel_out      = w_sel;
   assign pc_plus4_out = w_pc_plus4;

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Inputs : clk, rst (sync, active-high), stall_in, jump/jr/branch requests
//          with targets, imem_data_in (combinational read of imem_addr_out).
// Outputs: pc_out / imem_addr_out (current fetch PC), IF/ID register
//          (pc_plus4, instr, valid), redirect_out (combinational).
module if_stage_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC_P  = RESET_PC,
   parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        jump_in,
   input  logic [31:0] jump_target_in,
   input  logic        jr_in,
   input  logic [31:0] jr_target_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   input  logic [31:0] imem_data_in,
   output logic [31:0] imem_addr_out,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_pc_plus4_out,
   output logic [31:0] if_id_instr_out,
   output logic        if_id_valid_out,
   output logic        redirect_out
);

   logic [31:0] r_pc;
   logic [31:0] r_if_id_pc_plus4;
   logic [31:0] r_if_id_instr;
   logic        r_if_id_valid;

   logic [1:0]  w_sel;
   logic [31:0] w_next_pc;
   logic [31:0] w_pc_plus4;
   logic        w_redirect;

   next_pc_select u_next_pc_select (
      .pc_in            (r_pc),
      .branch_taken_in  (branch_taken_in),
      .branch_target_in (branch_target_in),
      .jr_in            (jr_in),
      .jr_target_in     (jr_target_in),
      .jump_in          (jump_in),
      .jump_target_in   (jump_target_in),
      .sel_out          (w_sel),
      .next_pc_out      (w_next_pc),
      .pc_plus4_out     (w_pc_plus4)
   );

   assign w_redirect = (w_sel != SEQ);

   // Redirect outranks stall: the instruction being held is on the wrong
   // path, so holding it would be pointless.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc             <= RESET_PC_P;
         r_if_id_pc_plus4 <= 32'h0;
         r_if_id_instr    <= NOP_INSTR_P;
         r_if_id_valid    <= 1'b0;
      end else if (w_redirect) begin
         r_pc             <= w_next_pc;
         r_if_id_pc_plus4 <= 32'h0;
         r_if_id_instr    <= NOP_INSTR_P;
         r_if_id_valid    <= 1'b0;
      end else if (!stall_in) begin
         r_pc             <= w_next_pc;
         r_if_id_pc_plus4 <= w_pc_plus4;
         r_if_id_instr    <= imem_data_in;
         r_if_id_valid    <= 1'b1;
      end
   end

   assign pc_out             = r_pc;
   assign imem_addr_out      = r_pc;
   assign if_id_pc_plus4_out = r_if_id_pc_plus4;
   assign if_id_instr_out    = r_if_id_instr;
   assign if_id_valid_out    = r_if_id_valid;
   assign redirect_out       = w_redirect;

endmodule
